noc_output_arbiter: RTL and testbench
=====================================

# noc_output_arbiter

Per-output-port arbiter and flow controller for the mesh router. It shares one output link between N_IN input ports using round-robin arbitration with wormhole locking per virtual channel. It tracks downstream buffer credits per VC and registers the winning flit onto the link. It sits between the input VC buffers and the output link of every router port.

## Interface
Parameters:
- N_IN, 5, number of requesting input ports (N, S, E, W, local)
- BUF_DEPTH, 4, downstream buffer depth per VC; initial credit count

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  N_IN  input i presents a flit
- req_flit_i  in  N_IN x flit_Data_withvc  flit per input; vc_Id is the output VC already chosen upstream
- req_ready_o  out  N_IN  one-hot grant; input i pops its flit this cycle
- out_valid_o  out  1  flit on out_flit_o is valid (registered)
- out_flit_o  out  flit_Data_withvc  registered granted flit
- credit_return_i  in  vc_Num  downstream freed one slot of VC v (one pulse = one credit)
- credit_err_o  out  1  sticky: credit returned while counter already at BUF_DEPTH

## Operation
- Per output VC v, the block keeps the following state:
  - credit[v]: width $clog2(BUF_DEPTH+1).
  - owner_valid[v] and owner_idx[v]: width $clog2(N_IN).
- Input i is eligible when req_valid_i[i] is set, v is the flit's vc_Id, credit[v] is greater than 0, and one of these holds:
  - The label is HEAD or HEADTAIL and owner_valid[v] is 0.
  - The label is BODY or TAIL, owner_valid[v] is 1, and owner_idx[v] equals i.
- A HEAD or HEADTAIL flit targeting an owned VC waits. A BODY or TAIL flit from a non-owner waits. Neither case raises an error.
- Arbitration is round-robin:
  - The search starts at rr_ptr and picks the first eligible input in ascending index order, wrapping at N_IN.
  - At most one req_ready_o bit is high, and only for an eligible input.
  - After a grant to input i, rr_ptr becomes (i+1) mod N_IN. With no grant, rr_ptr holds.
- Effects of a grant:
  - out_flit_o is loaded with the flit and out_valid_o is set to 1 on the next edge.
  - credit[v] is decremented.
  - A HEAD grant sets owner_valid[v]=1 and owner_idx[v]=i.
  - A TAIL grant clears owner_valid[v].
  - A HEADTAIL grant leaves ownership unchanged (it stays free).
  - A BODY grant leaves ownership unchanged.
- With no grant, out_valid_o is 0 next cycle and out_flit_o holds its last value.
- Credits:
  - credit_return_i[v] increments credit[v].
  - A simultaneous send and return on the same VC leaves the count unchanged.
  - A return with credit[v] equal to BUF_DEPTH and no send on v is ignored and sets credit_err_o.
- Different VCs interleave freely. Two packets may be in flight on the link at once, one per VC.

## Timing
- Reset values:
  - out_valid_o=0 and out_flit_o=0.
  - Every credit[v]=BUF_DEPTH.
  - All owner_valid=0 and owner_idx=0.
  - rr_ptr=0 and credit_err_o=0.
- req_ready_o is combinational from the current state and inputs (same-cycle grant). Its value is 0 while rst is high.
- Latency: a flit granted in cycle t appears with out_valid_o=1 in cycle t+1.
- Throughput: one flit per cycle while credits last.
- Credit effect: a credit returned in cycle t makes the VC eligible in cycle t+1, not in the same cycle.
- Reset mid-packet drops all ownership and restores full credits. Upstream and downstream are reset together, so no flits are in flight.

## Structure
- The following belong in params_noc:
  - the BUF_DEPTH default,
  - the N_IN / port-index enum (LOCAL, NORTH, SOUTH, EAST, WEST),
  - the credit width constant.
- Use the existing flit_Data_withvc and flit_Data_Label from params_noc.
- One sub-module: rr_arbiter (N_IN request vector in, one-hot grant out, internal pointer updated on grant). It is reusable for the VC allocator.
- Credit counters and the ownership table stay in noc_output_arbiter.

## Test plan
- **Single HEADTAIL:** after reset, input 2 sends HEADTAIL on VC0 → req_ready_o=5'b00100 in the same cycle; out_valid_o=1 next cycle with the identical flit; credit[0]=3; VC0 stays unowned.
- **Wormhole lock:**
  - Input 0 sends HEAD on VC1 while input 3 sends HEAD on VC1 → input 0 is granted and owns VC1.
  - Input 3 stalls through input 0's BODY and TAIL.
  - Input 3's HEAD is granted the cycle after the TAIL grant.
- **Round-robin fairness:** inputs 0, 1 and 4 each stream HEADTAIL on alternating VCs with ample credit returns → the grant order is 0, 1, 4, 0, 1, 4.
- **Credit exhaustion:**
  - 4 HEADTAIL flits are sent on VC0 without returns → the 5th request stalls with req_ready_o=0.
  - One credit_return_i[0] pulse → the flit is granted the following cycle.
  - Simultaneous send and return leaves credit unchanged.
- **Credit overflow:** credit_return_i[1] is pulsed at full credit → credit[1] stays 4 and credit_err_o goes to 1 and stays 1 until rst.
- **Reset mid-packet:** input 1 owns VC0 after HEAD+BODY; rst for 1 cycle → all outputs return to reset values, credits are 4, and a new HEAD from input 2 on VC0 is granted immediately.

Source files
------------

// File: rtl/noc_output_arbiter_pkg.sv
// Shared NoC types and constants for the router output stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package params_noc;

   // Router geometry and downstream buffering defaults
   localparam int N_IN_DEF      = 5;
   localparam int BUF_DEPTH_DEF = 4;
   localparam int CREDIT_W      = $clog2(BUF_DEPTH_DEF + 1);

   // Virtual channels on each output link
   localparam int vc_Num = 2;
   localparam int VC_W   = (vc_Num > 1) ? $clog2(vc_Num) : 1;

   localparam int FLIT_DATA_W = 16;

   // Router port indices
   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      SOUTH = 3'd2,
      EAST  = 3'd3,
      WEST  = 3'd4
   } port_e;

   typedef enum logic [1:0] {
      HEAD     = 2'd0,
      BODY     = 2'd1,
      TAIL     = 2'd2,
      HEADTAIL = 2'd3
   } flit_Data_Label;

   typedef struct packed {
      flit_Data_Label          label;
      logic [VC_W-1:0]         vc_Id;
      logic [FLIT_DATA_W-1:0]  data;
   } flit_Data_withvc;

endpackage

// File: rtl/noc_output_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
// Latency: combinational grant; pointer moves to winner+1 on the next edge.
// Backpressure: none; a cycle with no request leaves the pointer unchanged.
// Ports: clk_i/rst_i (sync active-high), req_i request vector, gnt_o one-hot grant.
module rr_arbiter #(
   parameter int N = 5
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_o
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;

   always_comb begin
      logic          found;
      logic [PW-1:0] idx;
      found = 1'b0;
      idx   = '0;
      gnt_o = '0;
      ptr_d = ptr_q;
      // Walk from the pointer upward, wrapping at N; first hit wins.
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr_q) + k) % N);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            ptr_d      = PW'((int'(idx) + 1) % N);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/noc_output_arbiter.sv
// Output-port arbiter: round-robin over inputs with per-VC wormhole lock and credit flow control.
// Latency: grant is same-cycle combinational; granted flit is registered onto the link next cycle.
// Backpressure: an input waits while its VC has no credit or is locked by another packet.
// Ports: req_valid_i/req_flit_i/req_ready_o input side; out_valid_o/out_flit_o link;
//        credit_return_i one pulse per freed downstream slot; credit_err_o sticky overflow flag.
module noc_output_arbiter
   import params_noc::*;
#(
   parameter int N_IN      = N_IN_DEF,
   parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_IN-1:0]     req_valid_i,
   input  flit_Data_withvc     req_flit_i [N_IN],
   output logic [N_IN-1:0]     req_ready_o,
   output logic                out_valid_o,
   output flit_Data_withvc     out_flit_o,
   input  logic [vc_Num-1:0]   credit_return_i,
   output logic                credit_err_o
);

   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

   logic [CW-1:0]     credit_q    [vc_Num];
   logic [CW-1:0]     credit_d    [vc_Num];
   logic [vc_Num-1:0] owner_vld_q, owner_vld_d;
   logic [IW-1:0]     owner_idx_q [vc_Num];
   logic [IW-1:0]     owner_idx_d [vc_Num];
   logic              err_q, err_d;
   logic              out_vld_q, out_vld_d;
   flit_Data_withvc   out_flit_q, out_flit_d;

   logic [N_IN-1:0]   elig;
   logic [N_IN-1:0]   gnt;
   logic              gnt_any;
   logic [IW-1:0]     gnt_idx;
   flit_Data_withvc   gnt_flit;

   // Eligibility: needs credit, and either a free VC for a packet start or
   // ownership of the VC for a packet continuation. Held off during reset.
   always_comb begin
      logic [VC_W-1:0] v;
      logic            is_head;
      v       = '0;
      is_head = 1'b0;
      elig    = '0;
      for (int i = 0; i < N_IN; i++) begin
         v       = req_flit_i[i].vc_Id;
         is_head = (req_flit_i[i].label == HEAD) || (req_flit_i[i].label == HEADTAIL);
         if (!rst && req_valid_i[i] && (credit_q[v] != '0)) begin
            if (is_head) elig[i] = !owner_vld_q[v];
            else         elig[i] = owner_vld_q[v] && (owner_idx_q[v] == IW'(i));
         end
      end
   end

   rr_arbiter #(.N(N_IN)) u_rr (
      .clk_i (clk),
      .rst_i (rst),
      .req_i (elig),
      .gnt_o (gnt)
   );

   assign req_ready_o = gnt;

   // Grant is one-hot, so at most one iteration fires.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      gnt_flit = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (gnt[i]) begin
            gnt_any  = 1'b1;
            gnt_idx  = IW'(i);
            gnt_flit = req_flit_i[i];
         end
      end
   end

   always_comb begin
      logic send;
      send        = 1'b0;
      credit_d    = credit_q;
      owner_vld_d = owner_vld_q;
      owner_idx_d = owner_idx_q;
      err_d       = err_q;
      out_vld_d   = gnt_any;
      out_flit_d  = gnt_any ? gnt_flit : out_flit_q;
      for (int v = 0; v < vc_Num; v++) begin
         send = gnt_any && (gnt_flit.vc_Id == VC_W'(v));
         // Send and return in the same cycle cancel out.
         if (send && !credit_return_i[v]) begin
            credit_d[v] = credit_q[v] - 1'b1;
         end else if (!send && credit_return_i[v]) begin
            if (credit_q[v] == CW'(BUF_DEPTH)) err_d = 1'b1;
            else                               credit_d[v] = credit_q[v] + 1'b1;
         end
         // HEADTAIL and BODY leave ownership alone.
         if (send && gnt_flit.label == HEAD) begin
            owner_vld_d[v] = 1'b1;
            owner_idx_d[v] = gnt_idx;
         end else if (send && gnt_flit.label == TAIL) begin
            owner_vld_d[v] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < vc_Num; v++) begin
            credit_q[v]    <= CW'(BUF_DEPTH);
            owner_idx_q[v] <= '0;
         end
         owner_vld_q <= '0;
         err_q       <= 1'b0;
         out_vld_q   <= 1'b0;
         out_flit_q  <= '0;
      end else begin
         credit_q    <= credit_d;
         owner_idx_q <= owner_idx_d;
         owner_vld_q <= owner_vld_d;
         err_q       <= err_d;
         out_vld_q   <= out_vld_d;
         out_flit_q  <= out_flit_d;
      end
   end

   assign out_valid_o  = out_vld_q;
   assign out_flit_o   = out_flit_q;
   assign credit_err_o = err_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of credits, ownership and round-robin order.
module tb_noc_output_arbiter;
   import params_noc::*;

   localparam int N  = 5;
   localparam int BD = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid_i;
   flit_Data_withvc   req_flit_i [N];
   logic [N-1:0]      req_ready_o;
   logic              out_valid_o;
   flit_Data_withvc   out_flit_o;
   logic [vc_Num-1:0] credit_return_i;
   logic              credit_err_o;

   noc_output_arbiter #(.N_IN(N), .BUF_DEPTH(BD)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid_i     (req_valid_i),
      .req_flit_i      (req_flit_i),
      .req_ready_o     (req_ready_o),
      .out_valid_o     (out_valid_o),
      .out_flit_o      (out_flit_o),
      .credit_return_i (credit_return_i),
      .credit_err_o    (credit_err_o)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Behavioural reference state
   int              m_credit [vc_Num];
   bit              m_own_v  [vc_Num];
   int              m_own_i  [vc_Num];
   int              m_ptr;
   bit              m_err;
   bit              m_ov;
   flit_Data_withvc m_of;

   function automatic flit_Data_withvc mk(flit_Data_Label l, int vc, int d);
      flit_Data_withvc r;
      r.label = l;
      r.vc_Id = VC_W'(vc);
      r.data  = FLIT_DATA_W'(d);
      return r;
   endfunction

   function automatic void model_reset();
      for (int v = 0; v < vc_Num; v++) begin
         m_credit[v] = BD;
         m_own_v[v]  = 1'b0;
         m_own_i[v]  = 0;
      end
      m_ptr = 0;
      m_err = 1'b0;
      m_ov  = 1'b0;
      m_of  = '0;
   endfunction

   // Index of the input the rules say should win now, or -1.
   function automatic int model_pick();
      if (rst) return -1;
      for (int k = 0; k < N; k++) begin
         int i = (m_ptr + k) % N;
         if (req_valid_i[i]) begin
            flit_Data_withvc f = req_flit_i[i];
            int v = int'(f.vc_Id);
            bit starts = (f.label == HEAD) || (f.label == HEADTAIL);
            if (m_credit[v] > 0) begin
               if (starts && !m_own_v[v]) return i;
               if (!starts && m_own_v[v] && m_own_i[v] == i) return i;
            end
         end
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      int g = model_pick();
      if (g < 0) return '0;
      return N'(1) << g;
   endfunction

   task automatic idle();
      req_valid_i     = '0;
      credit_return_i = '0;
      for (int i = 0; i < N; i++) req_flit_i[i] = '0;
   endtask

   // Advance one clock; the model consumes the inputs that were stable before the edge.
   task automatic clock_edge();
      int g;
      flit_Data_withvc f;
      logic [vc_Num-1:0] cr;
      logic r;
      g  = model_pick();
      r  = rst;
      cr = credit_return_i;
      f  = (g >= 0) ? req_flit_i[g] : '0;
      @(posedge clk);
      if (r) model_reset();
      else begin
         m_ov = (g >= 0);
         if (g >= 0) begin
            m_of  = f;
            m_ptr = (g + 1) % N;
         end
         for (int v = 0; v < vc_Num; v++) begin
            bit send = (g >= 0) && (int'(f.vc_Id) == v);
            if (send && !cr[v]) m_credit[v]--;
            else if (!send && cr[v]) begin
               if (m_credit[v] == BD) m_err = 1'b1;
               else                   m_credit[v]++;
            end
         end
         if (g >= 0) begin
            if (f.label == HEAD) begin
               m_own_v[int'(f.vc_Id)] = 1'b1;
               m_own_i[int'(f.vc_Id)] = g;
            end else if (f.label == TAIL) begin
               m_own_v[int'(f.vc_Id)] = 1'b0;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      clock_edge();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      req_valid_i[0] = 1'b1;
      req_flit_i[0]  = mk(HEADTAIL, 0, 16'h11);
      #1;
      compared++;
      if (req_ready_o !== 5'b00000) begin
         mismatched++; $display("FAIL reset_ready: got %b want 00000", req_ready_o);
      end
      clock_edge();
      clock_edge();
      compared++;
      if (out_valid_o !== 1'b0 || out_flit_o !== '0 || credit_err_o !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_outputs: got valid=%b flit=%h err=%b want 0/0/0", out_valid_o, out_flit_o, credit_err_o);
      end
      rst = 1'b0;
      idle();
   endtask

   task automatic test_single_headtail();
      flit_Data_withvc f1, f2;
      do_reset();
      f1 = mk(HEADTAIL, 0, 16'hA5A5);
      req_valid_i[2] = 1'b1; req_flit_i[2] = f1;
      #1;
      compared++;
      if (req_ready_o !== 5'b00100) begin
         mismatched++; $display("FAIL single_grant: got %b want 00100", req_ready_o);
      end
      clock_edge();
      idle();
      compared++;
      if (out_valid_o !== 1'b1 || out_flit_o !== f1) begin
         mismatched++; $display("FAIL single_out: got %b/%h want 1/%h", out_valid_o, out_flit_o, f1);
      end
      // VC0 must still be free: another packet start is accepted right away.
      f2 = mk(HEADTAIL, 0, 16'h5A5A);
      req_valid_i[4] = 1'b1; req_flit_i[4] = f2;
      #1;
      compared++;
      if (req_ready_o !== 5'b10000) begin
         mismatched++; $display("FAIL single_unowned: got %b want 10000", req_ready_o);
      end
      clock_edge();
      idle();
      clock_edge();
      compared++;
      if (out_valid_o !== 1'b0 || out_flit_o !== f2) begin
         mismatched++; $display("FAIL single_hold: got %b/%h want 0/%h", out_valid_o, out_flit_o, f2);
      end
      // Two credits left on VC0.
      for (int k = 0; k < 3; k++) begin
         logic [N-1:0] want;
         want = (k < 2) ? 5'b00001 : 5'b00000;
         req_valid_i[0] = 1'b1; req_flit_i[0] = mk(HEADTAIL, 0, k);
         #1;
         compared++;
         if (req_ready_o !== want) begin
            mismatched++; $display("FAIL single_credit k=%0d: got %b want %b", k, req_ready_o, want);
         end
         clock_edge();
      end
      idle();
   endtask

   task automatic test_wormhole();
      do_reset();
      req_valid_i = 5'b01001;
      req_flit_i[0] = mk(HEAD, 1, 16'h0100);
      req_flit_i[3] = mk(HEAD, 1, 16'h0300);
      #1;
      compared++;
      if (req_ready_o !== 5'b00001) begin
         mismatched++; $display("FAIL worm_head: got %b want 00001", req_ready_o);
      end
      clock_edge();
      req_flit_i[0] = mk(BODY, 1, 16'h0101);
      #1;
      compared++;
      if (req_ready_o !== 5'b00001) begin
         mismatched++; $display("FAIL worm_body: got %b want 00001", req_ready_o);
      end
      clock_edge();
      req_flit_i[0] = mk(TAIL, 1, 16'h0102);
      #1;
      compared++;
      if (req_ready_o !== 5'b00001) begin
         mismatched++; $display("FAIL worm_tail: got %b want 00001", req_ready_o);
      end
      clock_edge();
      req_valid_i[0] = 1'b0;
      #1;
      compared++;
      if (req_ready_o !== 5'b01000 || out_flit_o !== mk(TAIL, 1, 16'h0102)) begin
         mismatched++; $display("FAIL worm_next: got %b/%h want 01000/%h", req_ready_o, out_flit_o, mk(TAIL, 1, 16'h0102));
      end
      clock_edge();
      idle();
      compared++;
      if (out_valid_o !== 1'b1 || out_flit_o !== mk(HEAD, 1, 16'h0300)) begin
         mismatched++; $display("FAIL worm_out: got %b/%h want 1/%h", out_valid_o, out_flit_o, mk(HEAD, 1, 16'h0300));
      end
   endtask

   task automatic test_round_robin();
      int order [6] = '{0, 1, 4, 0, 1, 4};
      do_reset();
      for (int c = 0; c < 6; c++) begin
         logic [N-1:0] want;
         req_valid_i = 5'b10011;
         req_flit_i[0] = mk(HEADTAIL, c % 2, c * 16 + 0);
         req_flit_i[1] = mk(HEADTAIL, c % 2, c * 16 + 1);
         req_flit_i[4] = mk(HEADTAIL, c % 2, c * 16 + 4);
         credit_return_i = '0;
         if (c > 0) credit_return_i[(c - 1) % 2] = 1'b1;
         want = N'(1) << order[c];
         #1;
         compared++;
         if (req_ready_o !== want) begin
            mismatched++; $display("FAIL rr_order c=%0d: got %b want %b", c, req_ready_o, want);
         end
         clock_edge();
      end
      idle();
      credit_return_i[1] = 1'b1;
      clock_edge();
      idle();
      compared++;
      if (credit_err_o !== 1'b0) begin
         mismatched++; $display("FAIL rr_err: got %b want 0", credit_err_o);
      end
   endtask

   task automatic test_credit_exhaust();
      do_reset();
      req_valid_i[0] = 1'b1;
      req_flit_i[0]  = mk(HEADTAIL, 0, 16'hC0);
      for (int k = 0; k < 5; k++) begin
         logic [N-1:0] want;
         want = (k < 4) ? 5'b00001 : 5'b00000;
         #1;
         compared++;
         if (req_ready_o !== want) begin
            mismatched++; $display("FAIL exh_send k=%0d: got %b want %b", k, req_ready_o, want);
         end
         clock_edge();
      end
      credit_return_i = 2'b01;
      #1;
      compared++;
      if (req_ready_o !== 5'b00000) begin
         mismatched++; $display("FAIL exh_same_cycle: got %b want 00000", req_ready_o);
      end
      clock_edge();
      // Credit is now 1: grant with a simultaneous return keeps it at 1.
      credit_return_i = 2'b01;
      #1;
      compared++;
      if (req_ready_o !== 5'b00001) begin
         mismatched++; $display("FAIL exh_after_return: got %b want 00001", req_ready_o);
      end
      clock_edge();
      credit_return_i = 2'b00;
      #1;
      compared++;
      if (req_ready_o !== 5'b00001) begin
         mismatched++; $display("FAIL exh_simul: got %b want 00001", req_ready_o);
      end
      clock_edge();
      #1;
      compared++;
      if (req_ready_o !== 5'b00000 || credit_err_o !== 1'b0) begin
         mismatched++; $display("FAIL exh_drained: got %b err=%b want 00000 err=0", req_ready_o, credit_err_o);
      end
      clock_edge();
      idle();
   endtask

   task automatic test_credit_overflow();
      do_reset();
      credit_return_i = 2'b10;
      clock_edge();
      credit_return_i = 2'b00;
      for (int k = 0; k < 3; k++) begin
         compared++;
         if (credit_err_o !== 1'b1) begin
            mismatched++; $display("FAIL ovf_sticky k=%0d: got %b want 1", k, credit_err_o);
         end
         clock_edge();
      end
      // Counter must not have grown past 4.
      req_valid_i[2] = 1'b1;
      req_flit_i[2]  = mk(HEADTAIL, 1, 16'hF1);
      for (int k = 0; k < 5; k++) begin
         logic [N-1:0] want;
         want = (k < 4) ? 5'b00100 : 5'b00000;
         #1;
         compared++;
         if (req_ready_o !== want) begin
            mismatched++; $display("FAIL ovf_credit k=%0d: got %b want %b", k, req_ready_o, want);
         end
         clock_edge();
      end
      do_reset();
      compared++;
      if (credit_err_o !== 1'b0) begin
         mismatched++; $display("FAIL ovf_clear: got %b want 0", credit_err_o);
      end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      req_valid_i[1] = 1'b1;
      req_flit_i[1]  = mk(HEAD, 0, 16'hB0);
      #1;
      compared++;
      if (req_ready_o !== 5'b00010) begin
         mismatched++; $display("FAIL mid_head: got %b want 00010", req_ready_o);
      end
      clock_edge();
      req_flit_i[1] = mk(BODY, 0, 16'hB1);
      clock_edge();
      idle();
      rst = 1'b1;
      req_valid_i[2] = 1'b1;
      req_flit_i[2]  = mk(HEAD, 0, 16'hD0);
      #1;
      compared++;
      if (req_ready_o !== 5'b00000) begin
         mismatched++; $display("FAIL mid_rst_ready: got %b want 00000", req_ready_o);
      end
      clock_edge();
      rst = 1'b0;
      compared++;
      if (out_valid_o !== 1'b0 || out_flit_o !== '0 || credit_err_o !== 1'b0) begin
         mismatched++; $display("FAIL mid_rst_out: got %b/%h/%b want 0/0/0", out_valid_o, out_flit_o, credit_err_o);
      end
      #1;
      compared++;
      if (req_ready_o !== 5'b00100) begin
         mismatched++; $display("FAIL mid_new_head: got %b want 00100", req_ready_o);
      end
      clock_edge();
      // Full credit again: three more flits fit, the fourth waits.
      req_flit_i[2] = mk(BODY, 0, 16'hD1);
      for (int k = 0; k < 4; k++) begin
         logic [N-1:0] want;
         want = (k < 3) ? 5'b00100 : 5'b00000;
         #1;
         compared++;
         if (req_ready_o !== want) begin
            mismatched++; $display("FAIL mid_credit k=%0d: got %b want %b", k, req_ready_o, want);
         end
         clock_edge();
      end
      idle();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         logic [N-1:0] want;
         for (int i = 0; i < N; i++) begin
            req_valid_i[i] = 1'($urandom_range(0, 1));
            req_flit_i[i]  = mk(flit_Data_Label'($urandom_range(0, 3)),
                                int'($urandom_range(0, vc_Num - 1)), int'($urandom_range(0, 65535)));
         end
         for (int v = 0; v < vc_Num; v++)
            credit_return_i[v] = ($urandom_range(0, 3) == 0) &&
                                 (m_credit[v] < BD || $urandom_range(0, 15) == 0);
         #1;
         want = exp_ready();
         compared++;
         if (req_ready_o !== want) begin
            mismatched++; $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready_o, want);
         end
         compared++;
         if (out_valid_o !== m_ov || out_flit_o !== m_of || credit_err_o !== m_err) begin
            mismatched++;
            $display("FAIL rand_out c=%0d: got %b/%h/%b want %b/%h/%b", c,
                     out_valid_o, out_flit_o, credit_err_o, m_ov, m_of, m_err);
         end
         clock_edge();
      end
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      idle();
      model_reset();
      #1;
      test_reset();
      test_single_headtail();
      test_wormhole();
      test_round_robin();
      test_credit_exhaust();
      test_credit_overflow();
      test_reset_mid_packet();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
